// File: rtl/vga_frame_engine_if.sv
// Bus bundle for the VGA frame engine: register write port, framebuffer read
// port and the video pins.
//   master : register decoder / framebuffer / pin side (drives reg_*, fb_rdata)
//   slave  : the engine (drives fb_raddr, video_*, vblank_pulse, cur_page, frame_cnt)
interface vga_frame_engine_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              reg_we;
    logic [1:0]        reg_addr;
    logic [31:0]       reg_wdata;
    logic [ADDR_W-1:0] fb_raddr;
    logic [7:0]        fb_rdata;
    logic [2:0]        video_red;
    logic [2:0]        video_green;
    logic [1:0]        video_blue;
    logic              video_hsync;
    logic              video_vsync;
    logic              video_de;
    logic              video_clk;
    logic              vblank_pulse;
    logic              cur_page;
    logic [15:0]       frame_cnt;

    modport master (
        output reg_we, reg_addr, reg_wdata, fb_rdata,
        input  fb_raddr, video_red, video_green, video_blue, video_hsync,
               video_vsync, video_de, video_clk, vblank_pulse, cur_page, frame_cnt
    );

    modport slave (
        input  reg_we, reg_addr, reg_wdata, fb_rdata,
        output fb_raddr, video_red, video_green, video_blue, video_hsync,
               video_vsync, video_de, video_clk, vblank_pulse, cur_page, frame_cnt
    );
endinterface

// File: rtl/vga_frame_engine.sv
// VGA scan-out engine: H/V timing, RGB332 fetch from a dual-page framebuffer
// with RD_LAT read latency, sync/DE pipelined to stay aligned with the pixel,
// vblank-locked page flip, 2x pixel doubling and a background colour.
// Ports:
//   clk_50M : pixel clock (also forwarded on bus.video_clk)
//   rst     : asynchronous active-high reset
//   bus     : slave side of vga_frame_engine_if (registers, fb read, video pins)
module vga_frame_engine #(
    parameter int unsigned HSIZE    = 800,
    parameter int unsigned HFP      = 856,
    parameter int unsigned HSP      = 976,
    parameter int unsigned HMAX     = 1039,
    parameter int unsigned VSIZE    = 600,
    parameter int unsigned VFP      = 637,
    parameter int unsigned VSP      = 643,
    parameter int unsigned VMAX     = 665,
    parameter bit          SYNC_POL = 1'b1,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned ADDR_W   = 20
) (
    input logic             clk_50M,
    input logic             rst,
    vga_frame_engine_if.slave bus
);
    localparam int unsigned HW   = $clog2(HMAX + 1);
    localparam int unsigned VW   = $clog2(VMAX + 1);
    localparam int unsigned PAGE = HSIZE * VSIZE;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       en;
        logic [7:0] bg;
    } stage_t;

    localparam stage_t STAGE_RST = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, en: 1'b0, bg: 8'h00};

    logic [HW-1:0]     h, h_n;
    logic [VW-1:0]     v, v_n;
    logic              enable, scale2x, page_req, page;
    logic [7:0]        bgcol;
    logic [15:0]       frames;
    logic              vblank;
    logic [ADDR_W-1:0] raddr, addr_n, line_off;
    logic              flip, wr_ctrl, wr_bg, active_n;
    stage_t            st0;
    stage_t            pipe [RD_LAT];
    stage_t            last;
    logic [7:0]        pixel, pix_q;
    logic              de_q, hs_q, vs_q;
    logic              unused_wdata;

    assign unused_wdata = ^bus.reg_wdata[31:8];

    // Next counter position; address and flip decisions are made against it
    // so that fb_raddr and the flip-point state line up with the counters.
    always_comb begin
        h_n = (h == HW'(HMAX)) ? '0 : h + HW'(1);
        v_n = v;
        if (h == HW'(HMAX)) begin
            v_n = (v == VW'(VMAX)) ? '0 : v + VW'(1);
        end
    end

    assign flip    = (h_n == '0) && (v_n == VW'(VSIZE));
    assign wr_ctrl = bus.reg_we && (bus.reg_addr == 2'd0);
    assign wr_bg   = bus.reg_we && (bus.reg_addr == 2'd1);

    // Framebuffer address for the next counter position
    always_comb begin
        active_n = (h_n < HW'(HSIZE)) && (v_n < VW'(VSIZE));
        if (scale2x) begin
            line_off = ADDR_W'(v_n >> 1) * ADDR_W'(HSIZE / 2) + ADDR_W'(h_n >> 1);
        end else begin
            line_off = ADDR_W'(v_n) * ADDR_W'(HSIZE) + ADDR_W'(h_n);
        end
        addr_n = '0;
        if (active_n) begin
            addr_n = (page ? ADDR_W'(PAGE) : '0) + line_off;
        end
    end

    // Stage 0 raw video controls for the current counter position
    always_comb begin
        st0.de = (h < HW'(HSIZE)) && (v < VW'(VSIZE));
        st0.hs = ((h >= HW'(HFP)) && (h < HW'(HSP))) ? SYNC_POL : ~SYNC_POL;
        st0.vs = ((v >= VW'(VFP)) && (v < VW'(VSP))) ? SYNC_POL : ~SYNC_POL;
        st0.en = enable;
        st0.bg = bgcol;
    end

    // Counters, control registers and flip point.
    // A page request written on the flip edge only lands after the clear, so it waits a frame.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            h        <= '0;
            v        <= '0;
            enable   <= 1'b0;
            scale2x  <= 1'b0;
            page_req <= 1'b0;
            page     <= 1'b0;
            bgcol    <= 8'h00;
            frames   <= 16'h0000;
            vblank   <= 1'b0;
            raddr    <= '0;
        end else begin
            h <= h_n;
            v <= v_n;
            if (wr_ctrl) begin
                enable  <= bus.reg_wdata[0];
                scale2x <= bus.reg_wdata[1];
            end
            if (wr_bg) begin
                bgcol <= bus.reg_wdata[7:0];
            end
            if (flip && page_req) begin
                page <= ~page;
            end
            page_req <= (page_req & ~flip) | (wr_ctrl & bus.reg_wdata[2]);
            if (flip) begin
                frames <= frames + 16'd1;
            end
            vblank <= flip;
            raddr  <= addr_n;
        end
    end

    // Delay line matching the framebuffer read latency
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe[i] <= STAGE_RST;
            end
        end else begin
            pipe[0] <= st0;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign last = pipe[RD_LAT-1];

    always_comb begin
        pixel = 8'h00;
        if (last.de) begin
            pixel = last.en ? bus.fb_rdata : last.bg;
        end
    end

    // Output register stage
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            pix_q <= 8'h00;
            de_q  <= 1'b0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
        end else begin
            pix_q <= pixel;
            de_q  <= last.de;
            hs_q  <= last.hs;
            vs_q  <= last.vs;
        end
    end

    assign bus.fb_raddr     = raddr;
    assign bus.video_red    = pix_q[2:0];
    assign bus.video_green  = pix_q[5:3];
    assign bus.video_blue   = pix_q[7:6];
    assign bus.video_hsync  = hs_q;
    assign bus.video_vsync  = vs_q;
    assign bus.video_de     = de_q;
    assign bus.video_clk    = clk_50M;
    assign bus.vblank_pulse = vblank;
    assign bus.cur_page     = page;
    assign bus.frame_cnt    = frames;
endmodule
